// File: rtl/cmd_registry_pkg.sv
// Shared types for the command registry: the command record, FSM states,
// staging word addresses and the staging-word update helper.
package cmd_registry_pkg;

    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] dfreq;
        logic [31:0] rate;
        logic [47:0] tstart;
        logic [15:0] n_impuls;
        logic [1:0]  typ;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tblank1;
        logic [31:0] tblank2;
    } cmd_t;

    typedef enum logic [1:0] {
        S_FREE  = 2'd0,
        S_CHECK = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    localparam logic [3:0] W_FREQ_LO   = 4'd0;
    localparam logic [3:0] W_FREQ_HI   = 4'd1;
    localparam logic [3:0] W_DFREQ_LO  = 4'd2;
    localparam logic [3:0] W_DFREQ_HI  = 4'd3;
    localparam logic [3:0] W_RATE      = 4'd4;
    localparam logic [3:0] W_TSTART_LO = 4'd5;
    localparam logic [3:0] W_TSTART_HI = 4'd6;
    localparam logic [3:0] W_NTYPE     = 4'd7;
    localparam logic [3:0] W_TI        = 4'd8;
    localparam logic [3:0] W_TP        = 4'd9;
    localparam logic [3:0] W_TBLANK1   = 4'd10;
    localparam logic [3:0] W_TBLANK2   = 4'd11;

    // Idle output record: start time parked at the far future.
    localparam cmd_t CMD_RESET = '{
        freq: '0, dfreq: '0, rate: '0, tstart: 48'hFFFF_FFFF_FFFF,
        n_impuls: '0, typ: '0, ti: '0, tp: '0, tblank1: '0, tblank2: '0
    };

    function automatic cmd_t apply_word(input cmd_t c, input logic [3:0] addr,
                                        input logic [31:0] d);
        cmd_t r;
        r = c;
        case (addr)
            W_FREQ_LO:   r.freq[31:0]   = d;
            W_FREQ_HI:   r.freq[47:32]  = d[15:0];
            W_DFREQ_LO:  r.dfreq[31:0]  = d;
            W_DFREQ_HI:  r.dfreq[47:32] = d[15:0];
            W_RATE:      r.rate         = d;
            W_TSTART_LO: r.tstart[31:0] = d;
            W_TSTART_HI: r.tstart[47:32] = d[15:0];
            W_NTYPE: begin
                r.n_impuls = d[15:0];
                r.typ      = d[17:16];
            end
            W_TI:        r.ti      = d;
            W_TP:        r.tp      = d;
            W_TBLANK1:   r.tblank1 = d;
            W_TBLANK2:   r.tblank2 = d;
            default:     r = c;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; the read register doubles as the dispatched
// command and keeps its value across flush.
module cmd_fifo
    import cmd_registry_pkg::*;
#(
    parameter int   DEPTH     = 8,
    parameter cmd_t RESET_VAL = CMD_RESET
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  cmd_t                     din_i,
    input  logic                     pop_i,
    output cmd_t                     dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    cmd_t           mem_q [DEPTH];
    cmd_t           dout_q;
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic           do_push, do_pop;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (count_o == '0);
    assign dout_o  = dout_q;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= RESET_VAL;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_pop) dout_q <= mem_q[rd_ptr_q[AW-1:0]];
        end
    end

endmodule

// File: rtl/cmd_registry.sv
// Command registry: stages host words, queues committed commands and hands
// the head to master_start, discarding commands whose start time has passed.
module cmd_registry
    import cmd_registry_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int LEAD_CYC = 16
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    CMD_WE,
    input  logic [3:0]              CMD_ADDR,
    input  logic [31:0]             CMD_DATA,
    input  logic                    CMD_COMMIT,
    input  logic                    FLUSH,
    input  logic [63:0]             TIME,
    input  logic                    REQ_COMMAND,
    output logic                    WR_DATA,
    output logic [47:0]             MEM_DDS_freq,
    output logic [47:0]             MEM_DDS_delta_freq,
    output logic [31:0]             MEM_DDS_delta_rate,
    output logic [47:0]             MEM_TIME_START,
    output logic [15:0]             MEM_N_impuls,
    output logic [1:0]              MEM_TYPE_impulse,
    output logic [31:0]             MEM_Interval_Ti,
    output logic [31:0]             MEM_Interval_Tp,
    output logic [31:0]             MEM_Tblank1,
    output logic [31:0]             MEM_Tblank2,
    output logic [$clog2(DEPTH):0]  FIFO_COUNT,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic                    OVERFLOW,
    output logic [15:0]             LATE_CNT
);
    cmd_t         stage_q, stage_d;
    cmd_t         head;
    state_t       state_q, state_d;
    logic         req_prev_q;
    logic         wr_data_q, wr_data_d;
    logic         overflow_q, overflow_d;
    logic [15:0]  late_cnt_q, late_cnt_d;
    logic         push, pop, req_rise, late;
    logic         time_hi_unused;

    assign time_hi_unused = ^TIME[63:48];

    cmd_fifo #(
        .DEPTH     (DEPTH),
        .RESET_VAL (CMD_RESET)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .flush_i (FLUSH),
        .push_i  (push),
        .din_i   (stage_q),
        .pop_i   (pop),
        .dout_o  (head),
        .count_o (FIFO_COUNT),
        .full_o  (FULL),
        .empty_o (EMPTY)
    );

    assign req_rise = REQ_COMMAND & ~req_prev_q;
    assign late     = {1'b0, head.tstart} < ({1'b0, TIME[47:0]} + 49'(LEAD_CYC));
    // Commit takes stage_q, so a same-cycle word write lands after the push.
    assign push     = CMD_COMMIT & ~FLUSH;

    always_comb begin
        stage_d    = stage_q;
        state_d    = state_q;
        wr_data_d  = 1'b0;
        late_cnt_d = late_cnt_q;
        pop        = 1'b0;
        if (CMD_WE) stage_d = apply_word(stage_q, CMD_ADDR, CMD_DATA);
        case (state_q)
            S_FREE: begin
                if (!EMPTY) begin
                    pop     = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (late) begin
                    if (late_cnt_q != 16'hFFFF) late_cnt_d = late_cnt_q + 16'd1;
                    state_d = S_FREE;
                end else begin
                    wr_data_d = 1'b1;
                    state_d   = S_HELD;
                end
            end
            S_HELD: begin
                if (req_rise) state_d = S_FREE;
            end
            default: state_d = S_FREE;
        endcase
        if (FLUSH) begin
            state_d    = S_FREE;
            pop        = 1'b0;
            wr_data_d  = 1'b0;
            late_cnt_d = late_cnt_q;
        end
        overflow_d = FLUSH ? 1'b0 : (overflow_q | (push & FULL & ~pop));
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stage_q    <= '0;
            state_q    <= S_FREE;
            req_prev_q <= 1'b0;
            wr_data_q  <= 1'b0;
            overflow_q <= 1'b0;
            late_cnt_q <= '0;
        end else begin
            stage_q    <= stage_d;
            state_q    <= state_d;
            req_prev_q <= REQ_COMMAND;
            wr_data_q  <= wr_data_d;
            overflow_q <= overflow_d;
            late_cnt_q <= late_cnt_d;
        end
    end

    assign WR_DATA            = wr_data_q;
    assign OVERFLOW           = overflow_q;
    assign LATE_CNT           = late_cnt_q;
    assign MEM_DDS_freq       = head.freq;
    assign MEM_DDS_delta_freq = head.dfreq;
    assign MEM_DDS_delta_rate = head.rate;
    assign MEM_TIME_START     = head.tstart;
    assign MEM_N_impuls       = head.n_impuls;
    assign MEM_TYPE_impulse   = head.typ;
    assign MEM_Interval_Ti    = head.ti;
    assign MEM_Interval_Tp    = head.tp;
    assign MEM_Tblank1        = head.tblank1;
    assign MEM_Tblank2        = head.tblank2;

endmodule

// File: tb/tb_cmd_registry.sv
// Directed bench for cmd_registry with a scoreboard of expected dispatches.
module tb_cmd_registry;
    import cmd_registry_pkg::*;

    localparam int DEPTH = 8;
    localparam int LEAD  = 16;

    logic        CLK = 1'b0, RESET_N = 1'b0;
    logic        CMD_WE = 1'b0, CMD_COMMIT = 1'b0, FLUSH = 1'b0, REQ_COMMAND = 1'b0;
    logic [3:0]  CMD_ADDR = '0;
    logic [31:0] CMD_DATA = '0;
    logic [63:0] TIME;
    logic        WR_DATA, FULL, EMPTY, OVERFLOW;
    logic [47:0] MEM_DDS_freq, MEM_DDS_delta_freq, MEM_TIME_START;
    logic [31:0] MEM_DDS_delta_rate, MEM_Interval_Ti, MEM_Interval_Tp, MEM_Tblank1, MEM_Tblank2;
    logic [15:0] MEM_N_impuls, LATE_CNT;
    logic [1:0]  MEM_TYPE_impulse;
    logic [$clog2(DEPTH):0] FIFO_COUNT;

    cmd_registry #(.DEPTH(DEPTH), .LEAD_CYC(LEAD)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CMD_WE(CMD_WE), .CMD_ADDR(CMD_ADDR),
        .CMD_DATA(CMD_DATA), .CMD_COMMIT(CMD_COMMIT), .FLUSH(FLUSH), .TIME(TIME),
        .REQ_COMMAND(REQ_COMMAND), .WR_DATA(WR_DATA), .MEM_DDS_freq(MEM_DDS_freq),
        .MEM_DDS_delta_freq(MEM_DDS_delta_freq), .MEM_DDS_delta_rate(MEM_DDS_delta_rate),
        .MEM_TIME_START(MEM_TIME_START), .MEM_N_impuls(MEM_N_impuls),
        .MEM_TYPE_impulse(MEM_TYPE_impulse), .MEM_Interval_Ti(MEM_Interval_Ti),
        .MEM_Interval_Tp(MEM_Interval_Tp), .MEM_Tblank1(MEM_Tblank1),
        .MEM_Tblank2(MEM_Tblank2), .FIFO_COUNT(FIFO_COUNT), .FULL(FULL), .EMPTY(EMPTY),
        .OVERFLOW(OVERFLOW), .LATE_CNT(LATE_CNT)
    );

    always #10 CLK = ~CLK;

    logic [63:0] time_cnt = 64'd0;
    always @(posedge CLK) time_cnt <= time_cnt + 64'd1;
    assign TIME = time_cnt;

    typedef struct { cmd_t c; bit late; } exp_t;
    exp_t exp_q[$];
    cmd_t stg = '0;
    cmd_t obs_cmd;
    int   n_checks = 0, n_fail = 0, disp_cnt = 0, exp_late = 0;

    assign obs_cmd = {MEM_DDS_freq, MEM_DDS_delta_freq, MEM_DDS_delta_rate, MEM_TIME_START,
                      MEM_N_impuls, MEM_TYPE_impulse, MEM_Interval_Ti, MEM_Interval_Tp,
                      MEM_Tblank1, MEM_Tblank2};

    task automatic chk(input string tag, input logic [321:0] obs, input logic [321:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t put_word(input cmd_t c, input int a, input logic [31:0] d);
        cmd_t r = c;
        case (a)
            0:  r.freq[31:0]    = d;
            1:  r.freq[47:32]   = d[15:0];
            2:  r.dfreq[31:0]   = d;
            3:  r.dfreq[47:32]  = d[15:0];
            4:  r.rate          = d;
            5:  r.tstart[31:0]  = d;
            6:  r.tstart[47:32] = d[15:0];
            7:  begin r.n_impuls = d[15:0]; r.typ = d[17:16]; end
            8:  r.ti            = d;
            9:  r.tp            = d;
            10: r.tblank1       = d;
            11: r.tblank2       = d;
            default: r = c;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] get_word(input cmd_t c, input int a);
        case (a)
            0:  return c.freq[31:0];
            1:  return {16'h0, c.freq[47:32]};
            2:  return c.dfreq[31:0];
            3:  return {16'h0, c.dfreq[47:32]};
            4:  return c.rate;
            5:  return c.tstart[31:0];
            6:  return {16'h0, c.tstart[47:32]};
            7:  return {14'h0, c.typ, c.n_impuls};
            8:  return c.ti;
            9:  return c.tp;
            10: return c.tblank1;
            11: return c.tblank2;
            default: return 32'h0;
        endcase
    endfunction

    // Each WR_DATA pulse retires the oldest non-late expected command.
    always @(negedge CLK) begin
        if (RESET_N && WR_DATA === 1'b1) begin
            while (exp_q.size() > 0 && exp_q[0].late) begin
                void'(exp_q.pop_front());
                exp_late++;
            end
            chk("dispatch_expected", 322'(exp_q.size() != 0), 322'(1));
            if (exp_q.size() != 0) chk("dispatch_cmd", obs_cmd, exp_q.pop_front().c);
            disp_cnt++;
            $display("dispatch %0d: tstart=%h ti=%h late_cnt=%0d", disp_cnt,
                     MEM_TIME_START, MEM_Interval_Ti, LATE_CNT);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cycle(input bit we, input int addr, input logic [31:0] data,
                         input bit commit, input bit acc);
        CMD_WE = we; CMD_ADDR = addr[3:0]; CMD_DATA = data; CMD_COMMIT = commit;
        if (commit && acc)
            exp_q.push_back('{c: stg, late: (stg.tstart < time_cnt[47:0] + 48'(LEAD))});
        if (we) stg = put_word(stg, addr, data);
        tick();
        CMD_WE = 1'b0; CMD_COMMIT = 1'b0;
    endtask

    task automatic stage_all(input cmd_t c);
        for (int a = 0; a < 12; a++) cycle(1'b1, a, get_word(c, a), 1'b0, 1'b0);
    endtask

    task automatic req_pulse();
        REQ_COMMAND = 1'b1; tick();
        REQ_COMMAND = 1'b0; tick();
    endtask

    task automatic wait_disp(input int target, input int budget, input string tag);
        int n = 0;
        while (disp_cnt < target && n < budget) begin
            @(negedge CLK); #1; n++;
        end
        chk(tag, 322'(disp_cnt), 322'(target));
    endtask

    initial begin
        cmd_t ca;
        logic [47:0] t;

        repeat (3) tick();
        chk("rst_wr_data", 322'(WR_DATA), 322'(0));
        chk("rst_tstart", 322'(MEM_TIME_START), 322'(48'hFFFF_FFFF_FFFF));
        chk("rst_freq", 322'(MEM_DDS_freq), 322'(0));
        chk("rst_empty", 322'(EMPTY), 322'(1));
        chk("rst_full", 322'(FULL), 322'(0));
        chk("rst_count", 322'(FIFO_COUNT), 322'(0));
        chk("rst_overflow", 322'(OVERFLOW), 322'(0));
        chk("rst_late_cnt", 322'(LATE_CNT), 322'(0));
        RESET_N = 1'b1;
        tick();

        // First command: exact pulse timing relative to the commit edge.
        ca = '{freq: 48'h1234_5678_9ABC, dfreq: 48'hFEDC_BA98_7654, rate: 32'h0000_0100,
               tstart: time_cnt[47:0] + 48'd1000, n_impuls: 16'd4, typ: 2'd1,
               ti: 32'h0000_1111, tp: 32'h0000_2222, tblank1: 32'h33, tblank2: 32'h44};
        stage_all(ca);
        cycle(1'b0, 0, 32'h0, 1'b1, 1'b1);
        @(negedge CLK); chk("a_wr_edge0", 322'(WR_DATA), 322'(0));
        @(negedge CLK); chk("a_wr_edge1", 322'(WR_DATA), 322'(0));
        chk("a_mem_tstart", 322'(MEM_TIME_START), 322'(ca.tstart));
        chk("a_count", 322'(FIFO_COUNT), 322'(0));
        @(negedge CLK); chk("a_wr_edge2", 322'(WR_DATA), 322'(1));
        @(negedge CLK); chk("a_wr_edge3", 322'(WR_DATA), 322'(0));
        #1 chk("a_disp_cnt", 322'(disp_cnt), 322'(1));

        // Three queued commands; only the first goes without a request.
        req_pulse();
        ca.tstart = time_cnt[47:0] + 48'd100000;
        ca.ti = 32'hB0B0_0001;
        stage_all(ca);
        cycle(1'b0, 0, 32'h0, 1'b1, 1'b1);
        wait_disp(2, 10, "b_dispatched");
        cycle(1'b1, 8, 32'hC0C0_0002, 1'b0, 1'b0);
        cycle(1'b0, 0, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 9, 32'hD0D0_0003, 1'b1, 1'b1);
        repeat (5) tick();
        chk("hold_without_req", 322'(disp_cnt), 322'(2));
        chk("hold_count", 322'(FIFO_COUNT), 322'(2));
        req_pulse();
        wait_disp(3, 10, "c_dispatched");
        chk("c_count", 322'(FIFO_COUNT), 322'(1));

        // Late command is skipped and counted; the next one is dispatched.
        t = time_cnt[47:0] + 48'd5;
        cycle(1'b1, 5, t[31:0], 1'b0, 1'b0);
        cycle(1'b1, 6, {16'h0, t[47:32]}, 1'b0, 1'b0);
        cycle(1'b0, 0, 32'h0, 1'b1, 1'b1);
        t = time_cnt[47:0] + 48'd100000;
        cycle(1'b1, 5, t[31:0], 1'b0, 1'b0);
        cycle(1'b1, 6, {16'h0, t[47:32]}, 1'b0, 1'b0);
        cycle(1'b0, 0, 32'h0, 1'b1, 1'b1);
        req_pulse();
        wait_disp(4, 10, "d_dispatched");
        chk("d_count", 322'(FIFO_COUNT), 322'(2));
        req_pulse();
        wait_disp(5, 20, "f_dispatched");
        chk("late_cnt", 322'(LATE_CNT), 322'(1));
        chk("late_model", 322'(exp_late), 322'(1));
        chk("f_empty", 322'(EMPTY), 322'(1));

        // Ten back-to-back commits: one dispatched, eight stored, one dropped.
        req_pulse();
        for (int i = 0; i < 10; i++) cycle(1'b0, 0, 32'h0, 1'b1, i < 9);
        wait_disp(6, 10, "ovf_first_dispatched");
        chk("ovf_full", 322'(FULL), 322'(1));
        chk("ovf_overflow", 322'(OVERFLOW), 322'(1));
        chk("ovf_count", 322'(FIFO_COUNT), 322'(8));
        FLUSH = 1'b1; tick(); FLUSH = 1'b0;
        exp_q.delete();
        chk("flush_empty", 322'(EMPTY), 322'(1));
        chk("flush_overflow", 322'(OVERFLOW), 322'(0));
        chk("flush_count", 322'(FIFO_COUNT), 322'(0));
        chk("flush_mem_held", obs_cmd, stg);
        chk("flush_late_held", 322'(LATE_CNT), 322'(1));

        // Refill to full, then commit in the same cycle as a request-triggered pop.
        for (int i = 0; i < 9; i++) cycle(1'b1, 8, 32'h5000 + i, 1'b1, 1'b1);
        wait_disp(7, 10, "full_first_dispatched");
        chk("full_full", 322'(FULL), 322'(1));
        chk("full_count", 322'(FIFO_COUNT), 322'(8));
        REQ_COMMAND = 1'b1; tick();
        cycle(1'b1, 8, 32'h5100, 1'b1, 1'b1);
        REQ_COMMAND = 1'b0;
        chk("pushpop_count", 322'(FIFO_COUNT), 322'(8));
        chk("pushpop_overflow", 322'(OVERFLOW), 322'(0));
        chk("pushpop_full", 322'(FULL), 322'(1));
        wait_disp(8, 10, "pushpop_dispatched");

        // Asynchronous reset while the dispatch pulse is high.
        chk("pre_reset_wr", 322'(WR_DATA), 322'(1));
        RESET_N = 1'b0;
        #1;
        exp_q.delete();
        stg = '0;
        chk("areset_wr", 322'(WR_DATA), 322'(0));
        chk("areset_tstart", 322'(MEM_TIME_START), 322'(48'hFFFF_FFFF_FFFF));
        chk("areset_ti", 322'(MEM_Interval_Ti), 322'(0));
        chk("areset_empty", 322'(EMPTY), 322'(1));
        chk("areset_count", 322'(FIFO_COUNT), 322'(0));
        chk("areset_late", 322'(LATE_CNT), 322'(0));
        repeat (2) tick();
        RESET_N = 1'b1;
        repeat (3) tick();
        chk("post_reset_wr", 322'(WR_DATA), 322'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_registry.md
Name: cmd_registry

Overview:
- Real-time command registry feeding master_start.
- The host writes burst commands word-by-word into a staging record and commits each into a FIFO.
- The block hands the head command to master_start through the MEM_* bus with a one-cycle WR_DATA pulse.
- It loads the next command only after master_start raises REQ_COMMAND. Commands whose start time has already passed are discarded and counted.

Parameters:
- DEPTH, 8: FIFO depth in commands (power of 2, ≥2).
- LEAD_CYC, 16: minimum margin in CLK cycles (1/48 µs) between the current TIME and MEM_TIME_START at dispatch.

Ports:
- CLK  in  1  48 MHz system clock.
- RESET_N  in  1  asynchronous active-low reset.
- CMD_WE  in  1  staging word write strobe.
- CMD_ADDR  in  4  staging word index, 0..11.
- CMD_DATA  in  32  staging word data.
- CMD_COMMIT  in  1  push staging record into FIFO.
- FLUSH  in  1  discard all queued commands.
- TIME  in  64  system time from master_start.
- REQ_COMMAND  in  1  master_start request for the next command.
- WR_DATA  out  1  one-cycle load strobe to master_start.
- MEM_DDS_freq  out  48  DDS start frequency.
- MEM_DDS_delta_freq  out  48  DDS frequency step.
- MEM_DDS_delta_rate  out  32  DDS step rate.
- MEM_TIME_START  out  48  command start time.
- MEM_N_impuls  out  16  pulse count.
- MEM_TYPE_impulse  out  2  burst type.
- MEM_Interval_Ti  out  32  transmit interval.
- MEM_Interval_Tp  out  32  receive interval.
- MEM_Tblank1  out  32  pre-transmit blank.
- MEM_Tblank2  out  32  pre-receive blank.
- FIFO_COUNT  out  $clog2(DEPTH)+1  queued commands.
- FULL  out  1  FIFO full.
- EMPTY  out  1  FIFO empty.
- OVERFLOW  out  1  sticky: a commit was dropped.
- LATE_CNT  out  16  saturating count of discarded late commands.

Behaviour:
- Reset (RESET_N low, async) sets:
  - WR_DATA=0, all MEM_* = 0 except MEM_TIME_START = 48'hFFFF_FFFF_FFFF;
  - FIFO empty, FIFO_COUNT=0, FULL=0, EMPTY=1, OVERFLOW=0, LATE_CNT=0;
  - staging record = 0, state=S_FREE, REQ_COMMAND edge detector = 0.
- Staging word map (CMD_WE writes 32-bit word at CMD_ADDR; unused bits ignored; ADDR 12..15 ignored):
  - 0 freq[31:0]; 1 freq[47:32] in [15:0]; 2 dfreq[31:0]; 3 dfreq[47:32] in [15:0];
  - 4 rate; 5 tstart[31:0]; 6 tstart[47:32] in [15:0];
  - 7 n_impuls in [15:0], type in [17:16];
  - 8 Ti; 9 Tp; 10 Tblank1; 11 Tblank2.
- Staging contents persist after commit, so the host rewrites only the changed words.
- CMD_WE and CMD_COMMIT in the same cycle: the commit pushes the pre-write staging contents.
- Commit when FULL and no pop in the same cycle: record dropped, OVERFLOW set.
- Commit when FULL and pop in the same cycle: commit accepted; count unchanged.
- FLUSH: FIFO emptied, OVERFLOW cleared, state forced to S_FREE; MEM_* outputs and LATE_CNT held. FLUSH has priority over commit and pop in the same cycle.
- REQ_COMMAND rise is detected as a registered previous value of 0 and a current value of 1.
- FSM:
  - S_FREE: if !EMPTY, pop the head and register it into MEM_* at this edge → S_CHECK.
  - S_CHECK: late = MEM_TIME_START < TIME[47:0] + LEAD_CYC, 49-bit unsigned sum, no wrap handling.
    - Late: LATE_CNT+1 (saturating at FFFF) → S_FREE.
    - Not late: WR_DATA<=1 → S_HELD.
  - S_HELD: WR_DATA<=0 after one cycle; a REQ_COMMAND rise → S_FREE. MEM_* are stable throughout S_HELD.
- Latency: with the FIFO non-empty in S_FREE at edge n, MEM_* are valid after n+1 and WR_DATA is high for the cycle after n+2.
- A REQ_COMMAND rise outside S_HELD is ignored.

Decomposition:
- Package cmd_registry_pkg holds:
  - cmd_t packed struct of the ten fields (322 bits);
  - state enum;
  - word-address localparams.
- One sub-module, cmd_fifo: synchronous FIFO of cmd_t with registered read, same-cycle push/pop, count, full/empty, and flush.

Test Plan:
- Reset, then stage words 0..11 (freq=48'h123456789ABC, tstart=TIME+1000, n=4, type=1) and commit → WR_DATA one-cycle pulse 2 cycles later; MEM_* match the staged fields; MEM_TIME_START as staged.
- Queue 3 commands, REQ_COMMAND held low → only the first is dispatched, FIFO_COUNT=2. Raise REQ_COMMAND → second dispatched 3 cycles after the rise, FIFO_COUNT=1.
- Commit with tstart=TIME+5 (LEAD_CYC=16) → no WR_DATA, LATE_CNT=1, FIFO proceeds to the next command.
- With DEPTH=8, commit 10 times with no pop, 1 consumed by the initial dispatch → FULL=1, OVERFLOW=1, FIFO_COUNT=8. FLUSH → EMPTY=1, OVERFLOW=0, MEM_* unchanged.
- Commit while FULL with a REQ_COMMAND-triggered pop in the same cycle → accepted, FIFO_COUNT stays 8, OVERFLOW stays 0.
- Assert RESET_N low mid-S_HELD → WR_DATA=0, MEM_TIME_START=48'hFFFF_FFFF_FFFF, EMPTY=1 immediately (asynchronous).
